// File: rtl/memory_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter sharing one memory port among four requesters (optional watchdog: MEM_ARB_TIMEOUT_EN).
// Latency: grant/mem_en 1 cycle after req seen in IDLE; ack 1 cycle after mem_ready; one IDLE cycle between accesses.
// Backpressure: memory stalls via mem_ready (command held stable); requesters wait with req high until ack.
module memory_arbiter #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [3:0]          we,
  input  logic [4*ADDR_W-1:0] addr,
  input  logic [4*DATA_W-1:0] wdata,
  output logic [3:0]          gnt,
  output logic [3:0]          ack,
  output logic [3:0]          err,
  output logic [4*DATA_W-1:0] rdata,
  output logic                busy,
  output logic                mem_en,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] last;
  logic [1:0] win_idx;
  logic       we_l;
  logic [1:0] rr_cand;
  logic [1:0] pick_idx;
  logic       pick_vld;
  logic       timeout_hit;
  logic       finish_acc;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [4:0] tmo_cnt;

  // Watchdog: zero outside ACCESS so every access starts counting from 0.
  always_ff @(posedge clk) begin
    if (reset || state != ACCESS) tmo_cnt <= '0;
    else                          tmo_cnt <= tmo_cnt + 5'd1;
  end

  assign timeout_hit = (state == ACCESS) && !mem_ready && (tmo_cnt == 5'(TIMEOUT - 1));
`else
  // Watchdog compiled out: constant false, so ACCESS waits on mem_ready forever.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  assign finish_acc = (state == ACCESS) && (mem_ready || timeout_hit);
  assign busy       = (state != IDLE);

  // Round-robin pick: first requesting index after the previous winner, wrapping mod 4.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = last;
    rr_cand  = last;
    for (int k = 1; k <= 4; k++) begin
      rr_cand = last + k[1:0];
      if (!pick_vld && req[rr_cand]) begin
        pick_vld = 1'b1;
        pick_idx = rr_cand;
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state: IDLE -> ACCESS on any request, ACCESS -> DONE on completion or abort, DONE -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_vld) state_nxt = ACCESS;
      ACCESS:  if (finish_acc) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, memory command and completion pulses, all registered so the memory sees a stable command.
  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= 2'd3;
      win_idx   <= 2'd0;
      we_l      <= 1'b0;
      gnt       <= '0;
      ack       <= '0;
      err       <= '0;
      mem_en    <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        IDLE: begin
          gnt <= '0;
          if (pick_vld) begin
            win_idx   <= pick_idx;
            last      <= pick_idx;
            we_l      <= we[pick_idx];
            gnt       <= 4'b0001 << pick_idx;
            mem_en    <= 1'b1;
            mem_read  <= ~we[pick_idx];
            mem_write <= we[pick_idx];
            mem_addr  <= addr[pick_idx*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[pick_idx*DATA_W +: DATA_W];
          end
        end
        ACCESS: begin
          if (finish_acc) begin
            mem_en        <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            ack[win_idx]  <= 1'b1;
            err[win_idx]  <= timeout_hit;
          end
        end
        DONE: begin
          gnt <= '0;
        end
        default: begin
          gnt <= '0;
        end
      endcase
    end
  end

  // Read data: only the winner's slice, only on its own read completing with mem_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (state == ACCESS && mem_ready && !we_l) begin
      rdata[win_idx*DATA_W +: DATA_W] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
`timescale 1ns/1ps
// Scoreboard bench for memory_arbiter: a transaction-level round-robin model predicts completion order and data.
// Stimulus drives batches of requests; a separate monitor pops expectations on every ack and memory completion.
module tb_memory_arbiter;

  localparam int AW = 7;
  localparam int DW = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  typedef struct packed {
    logic [1:0]    idx;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          err;
    logic [31:0]   rdata;
  } exp_t;

  logic            clk;
  logic            reset;
  logic [3:0]      req;
  logic [3:0]      we;
  logic [4*AW-1:0] addr;
  logic [4*DW-1:0] wdata;
  logic [3:0]      gnt;
  logic [3:0]      ack;
  logic [3:0]      err;
  logic [4*DW-1:0] rdata;
  logic            busy;
  logic            mem_en;
  logic            mem_read;
  logic            mem_write;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ready;

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_err = 0;

  exp_t exp_ack[$];
  exp_t exp_mem[$];

  logic [7:0]  mem_arr   [128];   // memory as seen by the responder
  logic [7:0]  mem_model [128];   // memory as predicted by the model
  logic [31:0] model_rdata;
  int          m_last;
  int          resp_lat;          // >=0 fixed wait, -1 random 0..3, -2 never ready
  txn_t        plan [4][4];
  int          plan_n [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] oh(input int i);
    return 4'b0001 << i;
  endfunction

  task automatic present(input int i, input txn_t t);
    we[i]              = t.we;
    addr[i*AW +: AW]   = t.addr;
    wdata[i*DW +: DW]  = t.wdata;
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 4; i++) plan_n[i] = 0;
  endtask

  task automatic add_txn(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    plan[i][plan_n[i]].we    = w;
    plan[i][plan_n[i]].addr  = a;
    plan[i][plan_n[i]].wdata = d;
    plan_n[i]++;
  endtask

  // Predict completion order by rotating through requesters with work left, then drive the batch.
  task automatic run_batch();
    int   cnt [4];
    int   cur [4];
    int   w;
    int   first_w;
    int   total;
    int   cyc;
    bit   done;
    txn_t t;
    exp_t e;
    first_w = -1;
    total   = 0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = plan_n[i];
      cur[i] = 0;
      total += plan_n[i];
    end
    for (int n = 0; n < total; n++) begin
      w = -1;
      for (int k = 1; k <= 4; k++)
        if (w < 0 && cnt[(m_last + k) % 4] > 0) w = (m_last + k) % 4;
      t = plan[w][plan_n[w] - cnt[w]];
      cnt[w]--;
      m_last = w;
      if (first_w < 0) first_w = w;
      if (t.we) mem_model[t.addr] = t.wdata;
      else      model_rdata[w*8 +: 8] = mem_model[t.addr];
      e.idx   = 2'(w);
      e.we    = t.we;
      e.addr  = t.addr;
      e.wdata = t.wdata;
      e.err   = 1'b0;
      e.rdata = model_rdata;
      exp_ack.push_back(e);
      exp_mem.push_back(e);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      if (plan_n[i] > 0) begin
        present(i, plan[i][0]);
        req[i] = 1'b1;
      end
    @(negedge clk);
    chk("first_grant", {gnt, mem_en, busy}, {oh(first_w), 1'b1, 1'b1});
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 60 * total) begin
      for (int i = 0; i < 4; i++)
        if (ack[i]) begin
          cur[i]++;
          if (cur[i] < plan_n[i]) present(i, plan[i][cur[i]]);
          else                    req[i] = 1'b0;
        end
      done = 1'b1;
      for (int i = 0; i < 4; i++) if (cur[i] != plan_n[i]) done = 1'b0;
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("batch_done", done, 1);
    if (!done) req = '0;
    repeat (2) @(negedge clk);
  endtask

  // Memory responder: completes each access after resp_lat wait cycles.
  int wait_cnt;
  bit in_acc;
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    wait_cnt  = 0;
    in_acc    = 1'b0;
    forever begin
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 8'($urandom);
      if (!mem_en || reset) begin
        in_acc = 1'b0;
      end else begin
        if (!in_acc) begin
          in_acc   = 1'b1;
          wait_cnt = (resp_lat >= 0) ? resp_lat : ((resp_lat == -1) ? int'($urandom_range(0, 3)) : 0);
        end
        if (resp_lat != -2) begin
          if (wait_cnt == 0) begin
            mem_ready = 1'b1;
            if (mem_write) mem_arr[mem_addr] = mem_wdata;
            else           mem_rdata = mem_arr[mem_addr];
          end else begin
            wait_cnt--;
          end
        end
      end
    end
  end

  // Monitor: pops expectations when the DUT completes a memory access or pulses ack.
  exp_t        mon_e;
  logic [63:0] saved_cmd;
  bit          prev_en;
  bit          prev_done;
  initial begin
    prev_en   = 1'b0;
    prev_done = 1'b0;
    saved_cmd = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        prev_en   = 1'b0;
        prev_done = 1'b0;
      end else begin
        chk("gnt_onehot0", $onehot0(gnt), 1);
        chk("err_without_ack", err & ~ack, 0);
        if (mem_en && prev_en)
          chk("cmd_stable", {gnt, mem_read, mem_write, mem_addr, mem_wdata}, saved_cmd);
        saved_cmd = {gnt, mem_read, mem_write, mem_addr, mem_wdata};
        prev_en   = mem_en;
        if (prev_done) chk("ack_after_ready", ack != 0, 1);
        if (mem_en && mem_ready) begin
          if (exp_mem.size() == 0) begin
            chk("unexpected_mem_done", 1, 0);
          end else begin
            mon_e = exp_mem.pop_front();
            chk("mem_cmd", {gnt, mem_read, mem_write, mem_addr, (mon_e.we ? mem_wdata : 8'h00)},
                           {oh(mon_e.idx), ~mon_e.we, mon_e.we, mon_e.addr, (mon_e.we ? mon_e.wdata : 8'h00)});
          end
        end
        prev_done = mem_en && mem_ready;
        if (ack != 0) begin
          if (exp_ack.size() == 0) begin
            chk("unexpected_ack", ack, 0);
          end else begin
            mon_e = exp_ack.pop_front();
            chk("ack_gnt", {ack, gnt}, {oh(mon_e.idx), oh(mon_e.idx)});
            chk("ack_err", err, mon_e.err ? oh(mon_e.idx) : 4'b0000);
            chk("rdata", rdata, mon_e.rdata);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got %0d ns, expected less", $time);
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic [7:0] v;
    logic [AW-1:0] a;
    exp_t e;
    reset = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    resp_lat = -1; m_last = 3; model_rdata = '0;
    for (int i = 0; i < 128; i++) begin
      v = 8'($urandom);
      mem_arr[i]   = v;
      mem_model[i] = v;
    end
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {gnt, ack, err, busy}, 0);
    chk("reset_mem", {mem_en, mem_read, mem_write, mem_addr, mem_wdata}, 0);
    chk("reset_rdata", rdata, 0);
    reset = 1'b0;
    @(negedge clk);

    // All four requesting after reset: 0,1,2,3.
    clear_plan();
    for (int i = 0; i < 4; i++) add_txn(i, 1'($urandom), 7'($urandom), 8'($urandom));
    run_batch();

    // Single read, memory ready on the 2nd ACCESS cycle.
    resp_lat = 1;
    mem_arr[5] = 8'hA5; mem_model[5] = 8'hA5;
    clear_plan(); add_txn(0, 1'b0, 7'h05, 8'h00);
    run_batch();

    // Single write by requester 1.
    resp_lat = -1;
    clear_plan(); add_txn(1, 1'b1, 7'h7F, 8'h3C);
    run_batch();

    // Requesters 0 and 2 keep requesting: strict alternation.
    clear_plan();
    for (int n = 0; n < 3; n++) begin
      add_txn(0, 1'($urandom), 7'($urandom), 8'($urandom));
      add_txn(2, 1'($urandom), 7'($urandom), 8'($urandom));
    end
    run_batch();

    // Reset in the 2nd ACCESS cycle of a read by requester 3.
    resp_lat = -2;
    present(3, '{we: 1'b0, addr: 7'h11, wdata: 8'h00});
    req = 4'b1000;
    @(negedge clk);
    chk("rst_acc_gnt", gnt, 4'b1000);
    @(negedge clk);
    reset = 1'b1;
    req   = '0;
    @(negedge clk);
    chk("rst_acc_after", {mem_en, gnt, busy, ack}, 0);
    reset = 1'b0;
    m_last = 3;
    model_rdata = '0;
    resp_lat = -1;
    clear_plan();
    for (int i = 0; i < 4; i++) add_txn(i, 1'($urandom), 7'($urandom), 8'($urandom));
    run_batch();

    // Randomized batches.
    for (int b = 0; b < 40; b++) begin
      int mask;
      mask = int'($urandom_range(1, 15));
      clear_plan();
      for (int i = 0; i < 4; i++)
        if (mask[i]) begin
          int cnt;
          cnt = int'($urandom_range(1, 3));
          for (int n = 0; n < cnt; n++) add_txn(i, 1'($urandom), 7'($urandom), 8'($urandom));
        end
      run_batch();
    end

    // Memory that never answers.
    resp_lat = -2;
    a = 7'($urandom);
    e.idx = 2'd3; e.we = 1'b0; e.addr = a; e.wdata = 8'h00;
    m_last = 3;
`ifdef MEM_ARB_TIMEOUT_EN
    e.err   = 1'b1;
    e.rdata = model_rdata;
    exp_ack.push_back(e);
    present(3, '{we: 1'b0, addr: a, wdata: 8'h00});
    req = 4'b1000;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ack[3] == 1'b0 && cyc < 40);
    chk("timeout_ack_cycle", cyc, 17);
    req = '0;
`else
    e.err = 1'b0;
    model_rdata[31:24] = mem_model[a];
    e.rdata = model_rdata;
    exp_ack.push_back(e);
    exp_mem.push_back(e);
    present(3, '{we: 1'b0, addr: a, wdata: 8'h00});
    req = 4'b1000;
    repeat (110) @(negedge clk);
    chk("stall_busy", busy, 1);
    chk("stall_no_ack", exp_ack.size(), 1);
    resp_lat = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ack[3] == 1'b0 && cyc < 10);
    chk("stall_release_ack", ack[3], 1);
    req = '0;
`endif
    repeat (3) @(negedge clk);
    chk("queues_empty", exp_ack.size() + exp_mem.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
